// File: rtl/receiver_buffer.sv
// UART receive buffer: packs 4 received bytes (first byte MSB) into a word and
// queues words in a show-ahead FIFO that the core drains with read_req.
module receiver_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            input_data,
    input  logic                  input_valid,
    input  logic                  read_req,
    output logic [31:0]           output_data,
    output logic                  data_valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        B0,
        B1,
        B2,
        B3
    } byte_e;

    byte_e                 state_q;
    logic [23:0]           sr_q;
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic [31:0]           mem_q [DEPTH];
    logic                  overflow_q;

    logic        pop;
    logic        push_req;
    logic        push;
    logic [31:0] word;

    assign word     = {sr_q, input_data};
    assign pop      = read_req && (count_q != '0);
    assign push_req = input_valid && (state_q == B3);
    // A full FIFO still accepts the word when the head leaves on the same edge.
    assign push     = push_req && ((count_q != DEPTH_C) || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= B0;
            sr_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (input_valid) begin
                unique case (state_q)
                    B0: begin
                        sr_q[23:16] <= input_data;
                        state_q     <= B1;
                    end
                    B1: begin
                        sr_q[15:8] <= input_data;
                        state_q    <= B2;
                    end
                    B2: begin
                        sr_q[7:0] <= input_data;
                        state_q   <= B3;
                    end
                    B3: begin
                        state_q <= B0;
                    end
                endcase
            end
            if (push) begin
                mem_q[tail_q] <= word;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign output_data = mem_q[head_q];
    assign data_valid  = (count_q != '0);
    assign full        = (count_q == DEPTH_C);
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_receiver_buffer.sv
// Scoreboard bench for receiver_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the byte packer and word FIFO.
module tb_receiver_buffer;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic          CLK = 1'b0;
    logic          reset;
    logic [7:0]    input_data;
    logic          input_valid;
    logic          read_req;
    logic [31:0]   output_data;
    logic          data_valid;
    logic          full;
    logic [DL2:0]  count;
    logic          overflow;

    receiver_buffer #(.DEPTH_LOG2(DL2)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .input_data  (input_data),
        .input_valid (input_valid),
        .read_req    (read_req),
        .output_data (output_data),
        .data_valid  (data_valid),
        .full        (full),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: words the FIFO should hold, partially assembled word, sticky flag.
    logic [31:0] sb[$];
    int          m_cnt = 0;
    int          m_nb  = 0;
    logic [31:0] m_part = '0;
    bit          m_ovf = 0;
    int          pops = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_status();
        chk("count", 32'(count), 32'(m_cnt));
        chk("data_valid", 32'(data_valid), 32'(m_cnt != 0));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_cnt != 0 && sb.size() != 0)
            chk("head", output_data, sb[0]);
    endtask

    // One cycle: check state after previous edge, then drive inputs for next edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        bit pop;
        @(posedge CLK); #1;
        chk_status();
        input_valid = v;
        input_data  = d;
        read_req    = r;
        pop = r && (m_cnt > 0);
        if (v) begin
            m_part = {m_part[23:0], d};
            m_nb++;
            if (m_nb == 4) begin
                m_nb = 0;
                if (m_cnt < DEPTH || pop) begin
                    sb.push_back(m_part);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (pop) m_cnt--;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        reset = 1; input_valid = 0; read_req = 0; input_data = '0;
        @(posedge CLK); #1;
        reset = 0;
        sb.delete();
        m_cnt = 0; m_nb = 0; m_part = '0; m_ovf = 0;
        chk("rst_data", output_data, 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, r);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input bit r);
        for (int b = 3; b >= 0; b--) begin
            idle(int'($urandom_range(0, maxgap)), r);
            cyc(1, w[8*b +: 8], r);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands a word to the core.
    initial begin
        forever begin
            @(negedge CLK);
            if (!reset && read_req && data_valid) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("pop_unexpected", output_data, 32'hx);
                end else begin
                    chk("pop_word", output_data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        int p0;
        reset = 1; input_valid = 0; read_req = 0; input_data = '0;
        do_reset();

        // T1 single word with gaps, then one read
        send_word(32'h12345678, 5, 0);
        idle(1, 0);
        chk("t1_head", output_data, 32'h12345678);
        idle(1, 1);
        idle(2, 0);

        // T2 overflow on the fifth word, then drain
        for (int i = 1; i <= 5; i++) send_word(32'(i), 2, 0);
        idle(1, 0);
        chk("t2_ovf", 32'(overflow), 32'h1);
        idle(5, 1);
        idle(1, 0);

        // T3 full FIFO with pop on the same edge as the final byte
        do_reset();
        for (int i = 0; i < 4; i++) send_word(32'h100 + 32'(i), 1, 0);
        cyc(1, 8'hAA, 0); cyc(1, 8'hBB, 0); cyc(1, 8'hCC, 0);
        cyc(1, 8'hDD, 1);
        idle(1, 0);
        chk("t3_ovf", 32'(overflow), 32'h0);
        chk("t3_cnt", 32'(count), 32'h4);
        idle(6, 1);

        // T4 reset mid-word discards the partial bytes
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0);
        do_reset();
        send_word(32'hDEADBEEF, 0, 0);
        idle(1, 0);
        chk("t4_head", output_data, 32'hDEADBEEF);

        // T5 read_req held on empty FIFO, then a word arrives
        do_reset();
        p0 = pops;
        idle(10, 1);
        send_word(32'hCAFEF00D, 0, 1);
        idle(3, 1);
        chk("t5_pops", 32'(pops - p0), 32'h1);
        idle(1, 0);

        // T6 interleaved traffic across pointer wrap
        for (int i = 0; i < 12; i++) begin
            send_word($urandom, 2, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)), 1);
        end
        idle(8, 1);

        // Random traffic with occasional bursts that overflow
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc(1'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 3) == 0) || (i % 400 > 250));
        end
        idle(10, 1);
        idle(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
